// File: rtl/snow64_float_add_sub.sv
// Multi-cycle parametrised floating-point adder/subtractor with round-to-nearest-even.
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
module snow64_float_add_sub #(
    parameter int  WIDTH__ENC_EXP      = 8,
    parameter int  WIDTH__ENC_MANTISSA = 7,
    localparam int WIDTH__DATA         = 1 + WIDTH__ENC_EXP + WIDTH__ENC_MANTISSA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_start,
    input  logic                   in_op_sub,
    input  logic [WIDTH__DATA-1:0] in_a,
    input  logic [WIDTH__DATA-1:0] in_b,
    output logic [WIDTH__DATA-1:0] out_data,
    output logic                   out_data_valid,
    output logic                   out_can_accept_cmd
);
    localparam int E  = WIDTH__ENC_EXP;
    localparam int M  = WIDTH__ENC_MANTISSA;
    localparam int SW = M + 4;  // hidden + mantissa + guard/round/sticky
    localparam int EW = E + 1;  // one spare bit for carry into the exponent

    localparam logic [E-1:0] EXP_ONES = {E{1'b1}};
    localparam logic [E-1:0] EXP_SAT  = {{(E-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_big_q, sign_big_d;
    logic                   sign_small_q, sign_small_d;
    logic                   res_sign_q, res_sign_d;
    logic                   zero_q, zero_d;
    logic [EW-1:0]          exp_big_q, exp_big_d;
    logic [E-1:0]           exp_small_q, exp_small_d;
    logic [SW-1:0]          sig_big_q, sig_big_d;
    logic [SW-1:0]          sig_small_q, sig_small_d;
    logic [SW:0]            sum_q, sum_d;
    logic [WIDTH__DATA-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    function automatic logic [SW-1:0] make_sig(input logic [E-1:0] e, input logic [M-1:0] m);
        return (e == '0) ? '0 : {1'b1, m, 3'b000};
    endfunction

    function automatic int lead_zeros(input logic [SW-1:0] v);
        int lz;
        lz = SW;
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lz = SW - 1 - i;
        end
        return lz;
    endfunction

    // Operand decode; b's sign is flipped for subtraction so the core only adds.
    logic          a_sign, b_sign, swap;
    logic [E-1:0]  a_exp, b_exp;
    logic [M-1:0]  a_man, b_man;

    assign a_sign = in_a[WIDTH__DATA-1];
    assign a_exp  = in_a[M +: E];
    assign a_man  = in_a[M-1:0];
    assign b_sign = in_b[WIDTH__DATA-1] ^ in_op_sub;
    assign b_exp  = in_b[M +: E];
    assign b_man  = in_b[M-1:0];
    assign swap   = b_exp > a_exp;

    logic [E-1:0]  align_dist;
    logic [SW-1:0] align_mask, align_sig;

    assign align_dist = exp_big_q[E-1:0] - exp_small_q;
    assign align_mask = ~({SW{1'b1}} << align_dist);
    assign align_sig  = (int'(align_dist) >= SW)
                      ? {{(SW-1){1'b0}}, |sig_small_q}
                      : (sig_small_q >> align_dist) | {{(SW-1){1'b0}}, |(sig_small_q & align_mask)};

    int            norm_lz;
    logic [SW-1:0] norm_sig;

    assign norm_lz  = lead_zeros(sum_q[SW-1:0]);
    assign norm_sig = sum_q[SW-1:0] << norm_lz;

    // sig_big_q[3] is the result LSB, [2:0] are guard/round/sticky.
    logic          round_up;
    logic [M:0]    round_man;
    logic [EW-1:0] round_exp;

    assign round_up  = sig_big_q[2] & (sig_big_q[1] | sig_big_q[0] | sig_big_q[3]);
    assign round_man = {1'b0, sig_big_q[SW-2:3]} + {{M{1'b0}}, round_up};
    assign round_exp = exp_big_q + {{E{1'b0}}, round_man[M]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_start) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned and infers a latch.
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        res_sign_d   = res_sign_q;
        zero_d       = zero_q;
        exp_big_d    = exp_big_q;
        exp_small_d  = exp_small_q;
        sig_big_d    = sig_big_q;
        sig_small_d  = sig_small_q;
        sum_d        = sum_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    if (swap) begin
                        sign_big_d   = b_sign;
                        exp_big_d    = {1'b0, b_exp};
                        sig_big_d    = make_sig(b_exp, b_man);
                        sign_small_d = a_sign;
                        exp_small_d  = a_exp;
                        sig_small_d  = make_sig(a_exp, a_man);
                    end else begin
                        sign_big_d   = a_sign;
                        exp_big_d    = {1'b0, a_exp};
                        sig_big_d    = make_sig(a_exp, a_man);
                        sign_small_d = b_sign;
                        exp_small_d  = b_exp;
                        sig_small_d  = make_sig(b_exp, b_man);
                    end
                end
            end
            ST_ALIGN: sig_small_d = align_sig;
            ST_ADD: begin
                if (sign_big_q == sign_small_q) begin
                    sum_d      = {1'b0, sig_big_q} + {1'b0, sig_small_q};
                    res_sign_d = sign_big_q;
                end else if (sig_big_q >= sig_small_q) begin
                    sum_d      = {1'b0, sig_big_q} - {1'b0, sig_small_q};
                    res_sign_d = sign_big_q;
                end else begin
                    // Equal exponents with a larger second magnitude: result takes its sign.
                    sum_d      = {1'b0, sig_small_q} - {1'b0, sig_big_q};
                    res_sign_d = sign_small_q;
                end
            end
            ST_NORM: begin
                zero_d = 1'b0;
                if (sum_q[SW]) begin
                    sig_big_d = sum_q[SW:1] | {{(SW-1){1'b0}}, sum_q[0]};
                    exp_big_d = exp_big_q + EW'(1);
                end else if (sum_q == '0 || int'(exp_big_q) <= norm_lz) begin
                    zero_d = 1'b1;
                end else begin
                    sig_big_d = norm_sig;
                    exp_big_d = exp_big_q - EW'(norm_lz);
                end
            end
            ST_ROUND: begin
                out_valid_d = 1'b1;
                if (zero_q) begin
                    out_data_d = '0;
                end else if (round_exp >= {1'b0, EXP_ONES}) begin
                    out_data_d = {res_sign_q, EXP_SAT, {M{1'b1}}};
                end else begin
                    out_data_d = {res_sign_q, round_exp[E-1:0], round_man[M-1:0]};
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: datapath registers need no reset; each is written before the state that reads it.
    always_ff @(posedge clk) begin
        sign_big_q   <= sign_big_d;
        sign_small_q <= sign_small_d;
        res_sign_q   <= res_sign_d;
        zero_q       <= zero_d;
        exp_big_q    <= exp_big_d;
        exp_small_q  <= exp_small_d;
        sig_big_q    <= sig_big_d;
        sig_small_q  <= sig_small_d;
        sum_q        <= sum_d;
    end

    always_comb begin
        out_can_accept_cmd = (state_q == ST_IDLE);
        out_data           = out_data_q;
        out_data_valid     = out_valid_q;
    end
endmodule

// File: tb/tb_snow64_float_add_sub.sv
// Scoreboard bench: bf16 and fp16 instances, directed vectors with hand-computed results.
module tb_snow64_float_add_sub;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        bf_start = 1'b0, bf_op = 1'b0;
    logic [15:0] bf_a = '0, bf_b = '0, bf_out;
    logic        bf_valid, bf_can_accept;

    logic        fp_start = 1'b0, fp_op = 1'b0;
    logic [15:0] fp_a = '0, fp_b = '0, fp_out;
    logic        fp_valid, fp_can_accept;

    snow64_float_add_sub u_bf (
        .clk(clk), .rst_n(rst_n), .in_start(bf_start), .in_op_sub(bf_op),
        .in_a(bf_a), .in_b(bf_b), .out_data(bf_out), .out_data_valid(bf_valid),
        .out_can_accept_cmd(bf_can_accept)
    );

    snow64_float_add_sub #(.WIDTH__ENC_EXP(5), .WIDTH__ENC_MANTISSA(10)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_start(fp_start), .in_op_sub(fp_op),
        .in_a(fp_a), .in_b(fp_b), .out_data(fp_out), .out_data_valid(fp_valid),
        .out_can_accept_cmd(fp_can_accept)
    );

    typedef struct {
        logic [15:0] data;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic        op;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    exp_t bf_q[$];
    exp_t fp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vec_t bf_vecs [17] = '{
        '{16'h3F80, 1'b0, 16'h3F80, 16'h4000},
        '{16'h4040, 1'b1, 16'h3F80, 16'h4000},
        '{16'h3F80, 1'b1, 16'h3F80, 16'h0000},
        '{16'h3F80, 1'b1, 16'h3F7F, 16'h3B80},
        '{16'h3F80, 1'b0, 16'h3B80, 16'h3F80},
        '{16'h3F81, 1'b0, 16'h3B80, 16'h3F82},
        '{16'h7F7F, 1'b0, 16'h7F7F, 16'h7F7F},
        '{16'hFF7F, 1'b0, 16'hFF7F, 16'hFF7F},
        '{16'h3F80, 1'b0, 16'h0180, 16'h3F80},
        '{16'h3FFF, 1'b0, 16'h3B80, 16'h4000},
        '{16'h3F80, 1'b1, 16'h4000, 16'hBF80},
        '{16'h3F80, 1'b1, 16'h3FC0, 16'hBF00},
        '{16'h8000, 1'b0, 16'h8000, 16'h0000},
        '{16'h00C0, 1'b1, 16'h0080, 16'h0000},
        '{16'h7F80, 1'b0, 16'h0000, 16'h7F7F},
        '{16'h3F80, 1'b1, 16'hBF80, 16'h4000},
        '{16'hC000, 1'b0, 16'h3F80, 16'hBF80}
    };

    vec_t fp_vecs [7] = '{
        '{16'h3C00, 1'b0, 16'h3C00, 16'h4000},
        '{16'h4000, 1'b1, 16'h3C00, 16'h3C00},
        '{16'h3C00, 1'b0, 16'h3800, 16'h3E00},
        '{16'h7BFF, 1'b0, 16'h7BFF, 16'h7BFF},
        '{16'h7C00, 1'b0, 16'h0000, 16'h7BFF},
        '{16'h3C00, 1'b0, 16'h1000, 16'h3C00},
        '{16'h3C01, 1'b0, 16'h1000, 16'h3C02}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic bf_issue(input logic [15:0] a, input logic op, input logic [15:0] b,
                            input logic [15:0] r, input bit push, input bit timing);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!bf_can_accept && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bf_ready", 32'(bf_can_accept), 32'd1);
        bf_a = a; bf_b = b; bf_op = op; bf_start = 1'b1;
        if (push) begin
            e.data = r;
            e.acc  = cyc + 1;
            bf_q.push_back(e);
        end
        @(posedge clk); #1;
        bf_start = 1'b0;
        if (timing) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("bf_busy_can_accept", 32'(bf_can_accept), 32'd0);
            end
            @(negedge clk);
            check("bf_valid_pulse", 32'(bf_valid), 32'd1);
            check("bf_can_accept_after", 32'(bf_can_accept), 32'd1);
            @(negedge clk);
            check("bf_valid_one_cycle", 32'(bf_valid), 32'd0);
        end
    endtask

    task automatic fp_issue(input logic [15:0] a, input logic op, input logic [15:0] b,
                            input logic [15:0] r);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!fp_can_accept && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fp_ready", 32'(fp_can_accept), 32'd1);
        fp_a = a; fp_b = b; fp_op = op; fp_start = 1'b1;
        e.data = r;
        e.acc  = cyc + 1;
        fp_q.push_back(e);
        @(posedge clk); #1;
        fp_start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bf_valid) begin
            if (bf_q.size() == 0) begin
                check("bf_unexpected_valid", 32'(bf_valid), 32'd0);
            end else begin
                e = bf_q.pop_front();
                check("bf_data", 32'(bf_out), 32'(e.data));
                check("bf_latency", 32'(cyc - e.acc), 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fp_valid) begin
            if (fp_q.size() == 0) begin
                check("fp_unexpected_valid", 32'(fp_valid), 32'd0);
            end else begin
                e = fp_q.pop_front();
                check("fp_data", 32'(fp_out), 32'(e.data));
                check("fp_latency", 32'(cyc - e.acc), 32'd4);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bf_data", 32'(bf_out), 32'd0);
        check("reset_bf_valid", 32'(bf_valid), 32'd0);
        check("reset_bf_can_accept", 32'(bf_can_accept), 32'd1);
        check("reset_fp_data", 32'(fp_out), 32'd0);
        check("reset_fp_valid", 32'(fp_valid), 32'd0);
        check("reset_fp_can_accept", 32'(fp_can_accept), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bf_issue(bf_vecs[i].a, bf_vecs[i].op, bf_vecs[i].b, bf_vecs[i].r, 1'b1, i == 0);
        end

        // Second start during ALIGN must be ignored.
        bf_issue(16'h4040, 1'b0, 16'h3F80, 16'h4080, 1'b1, 1'b0);
        bf_a = 16'h3F80; bf_b = 16'h3F80; bf_start = 1'b1;
        @(posedge clk); #1;
        bf_start = 1'b0;

        // Reset while the next operation sits in NORM.
        bf_issue(16'h3F80, 1'b0, 16'h3F80, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("norm_reset_data", 32'(bf_out), 32'd0);
        check("norm_reset_valid", 32'(bf_valid), 32'd0);
        check("norm_reset_can_accept", 32'(bf_can_accept), 32'd1);
        rst_n = 1'b1;

        bf_issue(16'h4040, 1'b1, 16'h3F80, 16'h4000, 1'b1, 1'b1);

        for (int i = 0; i < 7; i++) begin
            fp_issue(fp_vecs[i].a, fp_vecs[i].op, fp_vecs[i].b, fp_vecs[i].r);
        end

        n = 0;
        while ((bf_q.size() != 0 || fp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bf_drain", 32'(bf_q.size()), 32'd0);
        check("fp_drain", 32'(fp_q.size()), 32'd0);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
